// File: rtl/fifo_arb_pkg.sv
// Shared types and defaults for the two-requester FIFO write arbiter.
// Holds the FSM state encoding, the grant_id encodings and the default widths.
package fifo_arb_pkg;

  localparam int DATA_W_DEF    = 128;
  localparam int MAX_BURST_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  localparam logic [1:0] GID_NONE = 2'd0;
  localparam logic [1:0] GID_REQ0 = 2'd1;
  localparam logic [1:0] GID_REQ1 = 2'd2;

  function automatic logic [1:0] gid_of(state_t s);
    case (s)
      GNT0:    return GID_REQ0;
      GNT1:    return GID_REQ1;
      default: return GID_NONE;
    endcase
  endfunction

endpackage

// File: rtl/arb_rr2.sv
// Two-way round-robin pick: on a tie, the requester not served last wins.
// rr_last = 0 means requester 0 was served last, 1 means requester 1.
module arb_rr2 (
  input  logic valid0,
  input  logic valid1,
  input  logic rr_last,
  output logic pick_valid,
  output logic pick_sel
);

  assign pick_valid = valid0 | valid1;
  assign pick_sel   = valid1 & (~valid0 | ~rr_last);

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Arbitrates two bursting write requesters onto a single FIFO write port.
// Zero-latency data path; grants last up to MAX_BURST beats or until the owner drops valid.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MAX_BURST = MAX_BURST_DEF,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req0_data,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req0_ready,
  output logic              req1_ready,
  input  logic              o_full,
  output logic              i_wren,
  output logic [DATA_W-1:0] i_wrdata,
  output logic [1:0]        grant_id,
  output logic [CNT_W-1:0]  beats0,
  output logic [CNT_W-1:0]  beats1
);

  localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);

  state_t     state, next_state;
  logic [7:0] burst_cnt;
  logic       rr_last, rr_next;
  logic       pick_valid, pick_sel;

  logic in_grant, cur_valid, beat, release_g, last_beat, grant_end, served;

  assign in_grant  = (state != IDLE);
  assign cur_valid = (state == GNT1) ? req1_valid : req0_valid;
  assign beat      = in_grant & cur_valid & ~o_full;
  // Release wins over a stalled FIFO: a dropped valid ends the grant even when full.
  assign release_g = in_grant & ~cur_valid;
  assign last_beat = beat & (burst_cnt == BURST_LAST);
  assign grant_end = release_g | last_beat;
  assign served    = beat | (burst_cnt != 8'd0);

  assign req0_ready = (state == GNT0) & ~o_full & ~rst;
  assign req1_ready = (state == GNT1) & ~o_full & ~rst;
  assign i_wren     = beat & ~rst;
  assign i_wrdata   = i_wren ? ((state == GNT1) ? req1_data : req0_data) : '0;

  // The pointer seen by the picker already reflects the grant being closed,
  // so back-to-back ties alternate without an idle cycle.
  always_comb begin
    rr_next = rr_last;
    if (grant_end && served) rr_next = (state == GNT1);
  end

  arb_rr2 u_rr (
    .valid0    (req0_valid),
    .valid1    (req1_valid),
    .rr_last   (rr_next),
    .pick_valid(pick_valid),
    .pick_sel  (pick_sel)
  );

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
  always_comb begin
    next_state = state;
    if (state == IDLE || grant_end) begin
      if (pick_valid) next_state = pick_sel ? GNT1 : GNT0;
      else            next_state = IDLE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      grant_id  <= GID_NONE;
      rr_last   <= 1'b1;
      burst_cnt <= 8'd0;
      beats0    <= '0;
      beats1    <= '0;
    end else begin
      state    <= next_state;
      grant_id <= gid_of(next_state);
      rr_last  <= rr_next;
      if (state == IDLE || grant_end) burst_cnt <= 8'd0;
      else if (beat)                  burst_cnt <= burst_cnt + 8'd1;
      if (beat && state == GNT0) beats0 <= beats0 + 1'b1;
      if (beat && state == GNT1) beats1 <= beats1 + 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized scoreboard bench for fifo_wr_arbiter against a grant-level reference model.
// Expected writes are queued by the stimulus side and consumed by an independent monitor.
module tb_fifo_wr_arbiter;

  localparam int DATA_W    = 128;
  localparam int MAX_BURST = 4;
  localparam int CNT_W     = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              req0_valid, req1_valid;
  logic [DATA_W-1:0] req0_data, req1_data;
  logic              req0_ready, req1_ready;
  logic              o_full;
  logic              i_wren;
  logic [DATA_W-1:0] i_wrdata;
  logic [1:0]        grant_id;
  logic [CNT_W-1:0]  beats0, beats1;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.DATA_W(DATA_W), .MAX_BURST(MAX_BURST), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req0_valid(req0_valid),
    .req1_valid(req1_valid),
    .req0_data (req0_data),
    .req1_data (req1_data),
    .req0_ready(req0_ready),
    .req1_ready(req1_ready),
    .o_full    (o_full),
    .i_wren    (i_wren),
    .i_wrdata  (i_wrdata),
    .grant_id  (grant_id),
    .beats0    (beats0),
    .beats1    (beats1)
  );

  int n_vec  = 0;
  int n_fail = 0;
  logic [DATA_W-1:0] wr_q[$];

  // Reference model: who owns the port, beats in this grant, who was served last.
  int owner;
  int burst;
  int last_srv;
  int m_beats[2];
  logic [1:0]       exp_gid;
  logic             exp_r0, exp_r1;
  logic [CNT_W-1:0] exp_b0, exp_b1;

  task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(bit v0, bit v1, int ls);
    if (v0 && v1) return (ls == 0) ? 1 : 0;
    if (v0) return 0;
    if (v1) return 1;
    return -1;
  endfunction

  function automatic logic [DATA_W-1:0] rand_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic model_reset();
    owner = -1; burst = 0; last_srv = 1;
    m_beats[0] = 0; m_beats[1] = 0;
  endtask

  task automatic model_step();
    bit v[2];
    bit beat;
    v[0] = req0_valid;
    v[1] = req1_valid;
    exp_gid = 2'(owner + 1);
    exp_r0  = (owner == 0) && !o_full;
    exp_r1  = (owner == 1) && !o_full;
    exp_b0  = CNT_W'(m_beats[0]);
    exp_b1  = CNT_W'(m_beats[1]);
    beat = (owner >= 0) && v[owner] && !o_full;
    if (beat) begin
      wr_q.push_back(owner == 0 ? req0_data : req1_data);
      m_beats[owner] = (m_beats[owner] + 1) % (1 << CNT_W);
    end
    if (owner < 0) begin
      owner = pick(v[0], v[1], last_srv); burst = 0;
    end else if (!v[owner]) begin
      if (burst > 0) last_srv = owner;
      owner = pick(v[0], v[1], last_srv); burst = 0;
    end else if (beat) begin
      burst++;
      if (burst == MAX_BURST) begin
        last_srv = owner;
        owner = pick(v[0], v[1], last_srv); burst = 0;
      end
    end
  endtask

  task automatic step(input int p0, input int p1, input int pf);
    @(negedge clk);
    rst        = 1'b0;
    req0_valid = ($urandom_range(99) < p0);
    req1_valid = ($urandom_range(99) < p1);
    req0_data  = rand_data();
    req1_data  = rand_data();
    o_full     = ($urandom_range(99) < pf);
    #1 model_step();
    #1;
    check("grant_id", grant_id, exp_gid);
    check("req0_ready", req0_ready, exp_r0);
    check("req1_ready", req1_ready, exp_r1);
    check("beats0", beats0, exp_b0);
    check("beats1", beats1, exp_b1);
  endtask

  task automatic check_reset_outputs();
    check("rst_wren", i_wren, 1'b0);
    check("rst_wrdata", i_wrdata, '0);
    check("rst_ready0", req0_ready, 1'b0);
    check("rst_ready1", req1_ready, 1'b0);
    check("rst_grant_id", grant_id, 2'd0);
    check("rst_beats0", beats0, '0);
    check("rst_beats1", beats1, '0);
  endtask

  // Monitor: consumes one expected beat each time the DUT writes.
  always @(negedge clk) begin
    #2;
    check("wren_while_full", i_wren & o_full, 1'b0);
    if (i_wren) begin
      if (wr_q.size() == 0) begin
        n_vec++; n_fail++;
        $display("FAIL spurious_write: got %0h expected no write at %0t", i_wrdata, $time);
      end else begin
        check("wrdata", i_wrdata, wr_q.pop_front());
      end
    end else begin
      check("idle_wrdata", i_wrdata, '0);
    end
  end

  initial begin
    rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0; o_full = 1'b0;
    req0_data = '0; req1_data = '0;
    model_reset();
    #3 check_reset_outputs();

    // Abort in the middle of the third beat of the first burst.
    repeat (4) step(100, 100, 0);
    #1 rst = 1'b1;
    #1 check_reset_outputs();
    model_reset();

    // Both always valid: alternating full bursts, tie first to requester 0.
    repeat (24) step(100, 100, 0);
    // Single requester held: back-to-back regrants and beat counter wrap.
    repeat (40) step(100, 0, 0);
    repeat (30) step(0, 100, 0);
    // FIFO backpressure with continuous requests.
    repeat (150) step(100, 100, 40);
    // Requesters dropping valid mid-burst, with and without backpressure.
    repeat (300) step(70, 70, 0);
    repeat (300) step(60, 60, 30);
    repeat (100) step(20, 90, 60);

    // Drain and confirm every expected write was seen.
    repeat (3) step(0, 0, 0);
    check("queue_empty", 128'(wr_q.size()), '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter DATA_W, default 128: write-data width; it SHALL match the FIFO data width.
REQ-002 Parameter MAX_BURST, default 4, legal range 1..255: maximum beats per grant.
REQ-003 Parameter CNT_W, default 16: width of the per-requester beat counters.
REQ-004 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-005 Port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 Ports req0_valid and req1_valid, input, 1 bit each: requester k has a data beat offered.
REQ-007 Ports req0_data and req1_data, input, DATA_W bits each: requester k write data.
REQ-008 Ports req0_ready and req1_ready, output, 1 bit each: beat accepted this cycle when valid and ready are both high.
REQ-009 Port o_full, input, 1 bit: FIFO full flag.
REQ-010 Port i_wren, output, 1 bit: FIFO write enable.
REQ-011 Port i_wrdata, output, DATA_W bits: FIFO write data.
REQ-012 Port grant_id, output, 2 bits: 0 = none, 1 = requester 0, 2 = requester 1.
REQ-013 Ports beats0 and beats1, output, CNT_W bits each: accepted-beat counts per requester.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, GNT0 and GNT1.
REQ-015 A beat for requester k SHALL occur when state is GNTk, reqk_valid=1 and o_full=0.
REQ-016 reqk_ready SHALL be combinational and equal (state==GNTk) & ~o_full; it SHALL NOT depend on reqk_valid.
REQ-017 On a beat, i_wren SHALL be 1 and i_wrdata SHALL equal reqk_data in the same cycle, giving zero-cycle latency.
REQ-018 With no beat, i_wren SHALL be 0 and i_wrdata SHALL be all-zeros.
REQ-019 The arbitration decision SHALL be made in IDLE and at the end of each grant.
- Only one requester valid: grant that requester.
- Both valid: grant the requester not served last, using the rr_last pointer.
- Neither valid: go to IDLE.
REQ-020 A burst counter SHALL clear on grant entry and increment on each beat.
REQ-021 The grant SHALL end at the clock edge after the MAX_BURST-th beat.
REQ-022 The grant SHALL also end on any cycle in GNTk with reqk_valid=0; that cycle is a release with no beat.
REQ-023 At grant end the FSM SHALL move directly to the next grant per REQ-019, without passing through IDLE.
REQ-024 rr_last SHALL update to k when leaving GNTk after one or more beats; a grant released with zero beats SHALL NOT update rr_last.
REQ-025 While o_full=1 in GNTk, the grant SHALL be held, the burst counter frozen, and no beat issued; there is no timeout.
REQ-026 If o_full and reqk_valid drop in the same cycle, the release rule (REQ-022) SHALL take priority.
REQ-027 i_wren SHALL never be 1 while o_full=1.
REQ-028 At most one reqk_ready SHALL be high in any cycle.
REQ-029 beatsk SHALL increment by 1 per beat of requester k and wrap modulo 2^CNT_W with no saturation.
REQ-030 grant_id SHALL be registered state: 0 in IDLE, 1 in GNT0, 2 in GNT1.
REQ-031 A requester that deasserts valid before ready SHALL lose no data and cause no spurious write.

Reset
REQ-032 Asserting rst SHALL immediately force: state IDLE, rr_last=1 (so requester 0 wins the first tie), burst counter 0, beats0=beats1=0, grant_id=0.
REQ-033 During reset, i_wren, req0_ready and req1_ready SHALL be 0 and i_wrdata SHALL be 0.
REQ-034 Reset asserted mid-burst SHALL abort the burst without a write in the reset cycle.
REQ-035 After reset release, the first grant SHALL be possible at the first rising clk edge.

Structure
REQ-036 A shared package fifo_arb_pkg SHALL hold the state enum (IDLE, GNT0, GNT1), the grant_id encodings, and the DATA_W and MAX_BURST defaults.
REQ-037 The block SHALL contain one sub-module, arb_rr2: the 2-way round-robin pick from valid0, valid1 and rr_last.
REQ-038 Counters, FSM and data mux SHALL be local to fifo_wr_arbiter.

Verification
REQ-039 Reset, then req0_valid=1 held for 6 cycles, MAX_BURST=4, o_full=0 -> grant_id=1 from cycle 1; 4 writes; 1 cycle with ready high on a new grant; then writes resume; beats0 reaches 5 after cycle 6.
REQ-040 Both requesters valid continuously, data 0xA0.. and 0xB0.. -> write order A0..A3 then B0..B3 then A4.., with zero idle cycles between bursts.
REQ-041 GNT0 after 2 beats, o_full=1 for 5 cycles -> i_wren=0 and grant_id=1 held; 2 further beats follow; grant then passes to requester 1.
REQ-042 req1 alone drops valid after 1 beat -> release cycle; next grant goes to req0 if valid; beats1=1.
REQ-043 rst asserted in the middle of the 3rd beat of a burst -> i_wren=0 immediately; all counters 0; after release, a tie is granted to requester 0.
REQ-044 beats0 preset near wrap (CNT_W=4), 17 beats -> beats0=1.
